pi_permute_engine: RTL and testbench
====================================

PI_PERMUTE_ENGINE -- requirements
Module: pi_permute_engine

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, meaning slices per state (power of two, 2..256).
REQ-002 The block SHALL have parameter MAX_ROUNDS, default 24, meaning the maximum permutation passes per state.
REQ-003 The block SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port in_valid  input  1  in_data holds a valid slice.
REQ-006 The block SHALL have port in_ready  output  1  block accepts a slice this cycle.
REQ-007 The block SHALL have port in_data  input  25  one 5x5 slice; bit index i = 5*y + x.
REQ-008 The block SHALL have port mode  input  2  0 = bypass, 1 = pi forward, 2 = pi inverse, 3 = treated as bypass.
REQ-009 The block SHALL have port rounds  input  clog2(MAX_ROUNDS+1)  passes to apply; values above MAX_ROUNDS saturate to MAX_ROUNDS.
REQ-010 The block SHALL have port out_valid  output  1  out_data holds a valid slice.
REQ-011 The block SHALL have port out_ready  input  1  consumer accepts out_data this cycle.
REQ-012 The block SHALL have port out_data  output  25  one permuted slice, same bit indexing as in_data.
REQ-013 The block SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, PERM and DRAIN; a slice transfers when valid and ready are both high.
REQ-015 in_ready SHALL be 1 in IDLE and LOAD and 0 otherwise; out_valid SHALL be 1 only in DRAIN.
REQ-016 The first accepted slice (in IDLE) SHALL latch mode and rounds for the whole state; it is stored at index 0 and moves the FSM to LOAD.
REQ-017 Slice k of a state SHALL be stored at buffer index k; mode and rounds SHALL be ignored on later slices.
REQ-018 After slice DEPTH-1 is accepted, the FSM SHALL go to PERM if the latched mode is 1 or 2 and rounds > 0, and to DRAIN otherwise.
REQ-019 PERM SHALL rewrite one slice per cycle in place, index 0 to DEPTH-1, for rounds passes: exactly rounds*DEPTH cycles, then DRAIN.
REQ-020 The forward map SHALL move bit (x,y) to a destination computed as follows.
- a = (x+3) mod 5, b = (y+3) mod 5, X = b, Y = (2a+3b) mod 5.
- Destination is bit 5*((Y+2) mod 5) + ((X+2) mod 5).
- All mod results are non-negative.
REQ-021 The inverse map SHALL be the exact inverse of the forward map, so that forward followed by inverse restores any slice.
REQ-022 DRAIN SHALL present buffer index 0 to DEPTH-1 in order, advancing only on out_ready; out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 After slice DEPTH-1 is accepted in DRAIN, the FSM SHALL go to IDLE, with in_ready=1 on the next cycle.
REQ-024 Slice and round counters SHALL wrap to 0 at DEPTH-1 and at the latched rounds respectively, with no off-by-one.
REQ-025 in_valid in PERM or DRAIN SHALL have no effect; out_ready outside DRAIN SHALL have no effect.

Reset
REQ-026 On rst=1 at a clock edge, the following SHALL hold.
- State returns to IDLE; counters and latched mode/rounds clear to 0.
- Outputs: out_valid=0, busy=0, in_ready=1, out_data=0.
REQ-027 rst SHALL take priority over every handshake.
REQ-028 Reset mid-LOAD, mid-PERM or mid-DRAIN SHALL abandon the state with no further output slices; buffer contents need not be cleared.

Structure
REQ-029 A shared package SHALL hold the following.
- Constant LANES=25.
- Mode encodings MODE_BYPASS/MODE_FWD/MODE_INV.
- The FSM state enum.
REQ-030 The combinational slice map SHALL be a sub-module pi_slice (in 25, inv 1, out 25); the engine SHALL use it as its only instance.
REQ-031 The buffer SHALL be a DEPTH x 25 register array; nothing combinational SHALL connect in_data to out_data.

Verification
REQ-032 The bench SHALL cover these directed scenarios.
- DEPTH=4, mode=1, rounds=1, slices 0x0000001, 0x0000002, 0x0001000, 0x1FFFFFF -> out 0x0000400, 0x0100000, 0x0001000, 0x1FFFFFF; PERM lasts exactly 4 cycles.
- mode=1 then a second state with mode=2, rounds=1, on the random slices -> output equals the original input.
- mode=0, rounds=5 -> output equals input with no PERM cycles; mode=1, rounds=0 -> same.
- out_ready toggled randomly in DRAIN -> no slice dropped or duplicated; out_data stable while stalled; in_ready=0 throughout.
- rst asserted on the 3rd PERM cycle -> next cycle busy=0, out_valid=0, in_ready=1; a fresh state then processes correctly.
- rounds=MAX_ROUNDS+3 -> PERM lasts MAX_ROUNDS*DEPTH cycles.

Source files
------------

// File: rtl/pi_permute_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pi_permute_engine_pkg
// Brief    : Shared constants, mode encodings, FSM states and the pi lane map
//            for the pi permutation engine.
// Revision : 1.0 - initial release
// ============================================================================
package pi_permute_engine_pkg;

  // Lanes in one 5x5 slice; bit index i = 5*y + x
  localparam int LANES = 25;

  // Operating modes; encoding 3 is handled as bypass by the engine
  localparam logic [1:0] MODE_BYPASS = 2'd0;
  localparam logic [1:0] MODE_FWD    = 2'd1;
  localparam logic [1:0] MODE_INV    = 2'd2;

  // Engine FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_PERM  = 2'd2,
    ST_DRAIN = 2'd3
  } pi_state_e;

  // Destination bit index of source bit i under the forward map.
  // All operands stay non-negative, so % yields a proper residue.
  function automatic int pi_fwd_dest(input int i);
    int x;
    int y;
    int a;
    int b;
    int xn;
    int yn;
    x  = i % 5;
    y  = i / 5;
    a  = (x + 3) % 5;
    b  = (y + 3) % 5;
    xn = b;
    yn = (2 * a + 3 * b) % 5;
    return 5 * ((yn + 2) % 5) + ((xn + 2) % 5);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pi_permute_engine_slice.sv
`default_nettype none
// ============================================================================
// Module   : pi_slice
// Brief    : Combinational pi lane permutation of one 25-bit slice, forward
//            or inverse. Pure wiring: each output bit is one input bit.
// Revision : 1.0 - initial release
// ============================================================================
module pi_slice
  import pi_permute_engine_pkg::*;
(
  input  logic [LANES-1:0] in,
  input  logic             inv,
  output logic [LANES-1:0] out
);

  logic [LANES-1:0] w_fwd;
  logic [LANES-1:0] w_inv;

  // The forward map is a bijection, so scattering in the forward direction and
  // gathering from the same destination gives the exact inverse.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_bit
    localparam int c_dst = pi_fwd_dest(gi);
    assign w_fwd[c_dst] = in[gi];
    assign w_inv[gi]    = in[c_dst];
  end

  assign out = inv ? w_inv : w_fwd;

endmodule
`default_nettype wire

// File: rtl/pi_permute_engine.sv
`default_nettype none
// ============================================================================
// Module   : pi_permute_engine
// Brief    : Buffers DEPTH slices, applies the pi permutation (forward or
//            inverse) in place for a latched number of passes, then drains
//            the buffer in order under valid/ready flow control.
// Revision : 1.0 - initial release
// ============================================================================
module pi_permute_engine
  import pi_permute_engine_pkg::*;
#(
  parameter int DEPTH      = 64,
  parameter int MAX_ROUNDS = 24
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [LANES-1:0]                  in_data,
  input  logic [1:0]                        mode,
  input  logic [$clog2(MAX_ROUNDS+1)-1:0]   rounds,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [LANES-1:0]                  out_data,
  output logic                              busy
);

  localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_rw = $clog2(MAX_ROUNDS + 1);

  localparam logic [1:0] c_st_idle  = ST_IDLE;
  localparam logic [1:0] c_st_load  = ST_LOAD;
  localparam logic [1:0] c_st_perm  = ST_PERM;
  localparam logic [1:0] c_st_drain = ST_DRAIN;

  localparam logic [c_aw-1:0] c_last_slice = c_aw'(DEPTH - 1);
  localparam logic [c_rw-1:0] c_max_rounds = c_rw'(MAX_ROUNDS);

  logic [1:0]       r_state;
  logic [1:0]       r_mode;
  logic [c_rw-1:0]  r_rounds;
  logic [c_aw-1:0]  r_slice;
  logic [c_rw-1:0]  r_round;
  logic [LANES-1:0] r_buf [DEPTH];

  logic [c_rw-1:0]  w_rounds_sat;
  logic             w_do_perm;
  logic [LANES-1:0] w_slice_rd;
  logic [LANES-1:0] w_perm_out;
  logic             w_buf_we;
  logic [c_aw-1:0]  w_buf_idx;
  logic [LANES-1:0] w_buf_din;

  assign w_rounds_sat = (rounds > c_max_rounds) ? c_max_rounds : rounds;
  assign w_do_perm    = ((r_mode == MODE_FWD) || (r_mode == MODE_INV)) &&
                        (r_rounds != '0);
  assign w_slice_rd   = r_buf[r_slice];

  pi_slice u_pi_slice (
    .in  (w_slice_rd),
    .inv (r_mode == MODE_INV),
    .out (w_perm_out)
  );

  // Buffer write port: incoming slices while loading, permuted slice in PERM
  always_comb begin
    w_buf_we  = 1'b0;
    w_buf_idx = r_slice;
    w_buf_din = in_data;
    if (!rst) begin
      case (r_state)
        c_st_idle: begin
          w_buf_we  = in_valid;
          w_buf_idx = '0;
        end
        c_st_load: w_buf_we = in_valid;
        c_st_perm: begin
          w_buf_we  = 1'b1;
          w_buf_din = w_perm_out;
        end
        default: w_buf_we = 1'b0;
      endcase
    end
  end

  // Slice storage; contents are left untouched by reset
  always_ff @(posedge clk) begin
    if (w_buf_we) begin
      r_buf[w_buf_idx] <= w_buf_din;
    end
  end

  // Control FSM with slice and round counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= c_st_idle;
      r_mode   <= MODE_BYPASS;
      r_rounds <= '0;
      r_slice  <= '0;
      r_round  <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (in_valid) begin
            r_mode   <= mode;
            r_rounds <= w_rounds_sat;
            r_slice  <= c_aw'(1);
            r_state  <= c_st_load;
          end
        end
        c_st_load: begin
          if (in_valid) begin
            if (r_slice == c_last_slice) begin
              r_slice <= '0;
              r_state <= w_do_perm ? c_st_perm : c_st_drain;
            end else begin
              r_slice <= r_slice + 1'b1;
            end
          end
        end
        c_st_perm: begin
          if (r_slice == c_last_slice) begin
            r_slice <= '0;
            if (r_round == r_rounds - 1'b1) begin
              r_round <= '0;
              r_state <= c_st_drain;
            end else begin
              r_round <= r_round + 1'b1;
            end
          end else begin
            r_slice <= r_slice + 1'b1;
          end
        end
        default: begin
          if (out_ready) begin
            if (r_slice == c_last_slice) begin
              r_slice <= '0;
              r_state <= c_st_idle;
            end else begin
              r_slice <= r_slice + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign in_ready  = (r_state == c_st_idle) || (r_state == c_st_load);
  assign out_valid = (r_state == c_st_drain);
  assign busy      = (r_state != c_st_idle);
  assign out_data  = out_valid ? w_slice_rd : '0;

endmodule
`default_nettype wire

// File: tb/tb_pi_permute_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_pi_permute_engine
// Brief    : Directed self-checking bench for pi_permute_engine (DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pi_permute_engine;

  localparam int DEPTH      = 4;
  localparam int MAX_ROUNDS = 24;
  localparam int RW         = $clog2(MAX_ROUNDS + 1);

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [24:0]   in_data;
  logic [1:0]    mode;
  logic [RW-1:0] rounds;
  logic          out_valid;
  logic          out_ready;
  logic [24:0]   out_data;
  logic          busy;

  int tests_run;
  int tests_failed;

  logic [24:0] vin  [DEPTH];
  logic [24:0] vout [DEPTH];
  logic [24:0] vexp [DEPTH];
  int          perm_cycles;
  int          stall_errs;
  int          ready_errs;
  bit          timed_out;

  pi_permute_engine #(
    .DEPTH      (DEPTH),
    .MAX_ROUNDS (MAX_ROUNDS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .mode      (mode),
    .rounds    (rounds),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference forward map straight from the lane formula
  function automatic logic [24:0] model_fwd(input logic [24:0] s);
    logic [24:0] r;
    int a;
    int b;
    int xn;
    int yn;
    r = '0;
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        a  = (x + 3) % 5;
        b  = (y + 3) % 5;
        xn = b;
        yn = (2 * a + 3 * b) % 5;
        r[5 * ((yn + 2) % 5) + ((xn + 2) % 5)] = s[5 * y + x];
      end
    end
    return r;
  endfunction

  // Send vin[] as one state; later slices carry junk mode/rounds
  task automatic send_state(input logic [1:0] m, input logic [RW-1:0] r);
    for (int k = 0; k < DEPTH; k++) begin
      in_valid = 1'b1;
      in_data  = vin[k];
      mode     = (k == 0) ? m : ~m;
      rounds   = (k == 0) ? r : ~r;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    mode     = 2'd0;
    rounds   = '0;
  endtask

  // Count cycles spent in PERM until out_valid rises (bounded)
  task automatic wait_perm();
    int n;
    n = 0;
    perm_cycles = 0;
    timed_out   = 1'b0;
    while (!out_valid) begin
      if (busy && !in_ready) perm_cycles++;
      n++;
      if (n > 1000) begin
        timed_out = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  // Collect DEPTH output slices into vout[], tallying protocol violations
  task automatic drain(input bit random_ready, input bit junk_in);
    int          got;
    int          n;
    bit          stalled;
    logic [24:0] held;
    got = 0; n = 0; stalled = 1'b0; held = '0;
    stall_errs = 0;
    ready_errs = 0;
    while (got < DEPTH && n < 300) begin
      out_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (junk_in) begin
        in_valid = 1'b1;
        in_data  = 25'($urandom);
      end
      if (stalled && out_data !== held) stall_errs++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) ready_errs++;
      if (out_ready) begin
        vout[got] = out_data;
        got++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held    = out_data;
      end
      @(posedge clk); #1;
      n++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    timed_out = (got < DEPTH);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 25'h1ABCDEF;
    mode = 2'd1;
    rounds = 5'd1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    tests_run++;
    if (out_data !== 25'h0) begin
      tests_failed++; $display("FAIL reset_out_data: got %h want 0", out_data);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run_directed(input string tag);
    vin[0] = 25'h0000001; vexp[0] = 25'h0000400;
    vin[1] = 25'h0000002; vexp[1] = 25'h0100000;
    vin[2] = 25'h0001000; vexp[2] = 25'h0001000;
    vin[3] = 25'h1FFFFFF; vexp[3] = 25'h1FFFFFF;
    send_state(2'd1, 5'd1);
    wait_perm();
    tests_run++;
    if (timed_out || perm_cycles != 4) begin
      tests_failed++;
      $display("FAIL %s_perm_cycles: got %0d want 4 (timeout=%0b)", tag, perm_cycles, timed_out);
    end
    drain(1'b0, 1'b0);
    for (int k = 0; k < DEPTH; k++) begin
      tests_run++;
      if (timed_out || vout[k] !== vexp[k]) begin
        tests_failed++;
        $display("FAIL %s_slice%0d: got %h want %h", tag, k, vout[k], vexp[k]);
      end
    end
    tests_run++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_back_to_idle: in_ready=%b busy=%b want 1/0", tag, in_ready, busy);
    end
  endtask

  task automatic test_fwd_vectors();
    run_directed("fwd_vec");
  endtask

  task automatic test_fwd_inv_roundtrip();
    logic [24:0] orig [DEPTH];
    for (int k = 0; k < DEPTH; k++) begin
      orig[k] = 25'($urandom);
      vin[k]  = orig[k];
    end
    send_state(2'd1, 5'd1);
    wait_perm();
    drain(1'b0, 1'b0);
    for (int k = 0; k < DEPTH; k++) begin
      tests_run++;
      if (timed_out || vout[k] !== model_fwd(orig[k])) begin
        tests_failed++;
        $display("FAIL rt_fwd%0d: got %h want %h", k, vout[k], model_fwd(orig[k]));
      end
      vin[k] = vout[k];
    end
    send_state(2'd2, 5'd1);
    wait_perm();
    tests_run++;
    if (timed_out || perm_cycles != DEPTH) begin
      tests_failed++; $display("FAIL rt_inv_perm_cycles: got %0d want %0d", perm_cycles, DEPTH);
    end
    drain(1'b0, 1'b0);
    for (int k = 0; k < DEPTH; k++) begin
      tests_run++;
      if (timed_out || vout[k] !== orig[k]) begin
        tests_failed++;
        $display("FAIL rt_inv%0d: got %h want %h", k, vout[k], orig[k]);
      end
    end
  endtask

  task automatic test_bypass();
    logic [1:0]    mset [3];
    logic [RW-1:0] rset [3];
    mset[0] = 2'd0; rset[0] = 5'd5;
    mset[1] = 2'd1; rset[1] = 5'd0;
    mset[2] = 2'd3; rset[2] = 5'd2;
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < DEPTH; k++) vin[k] = 25'($urandom);
      send_state(mset[c], rset[c]);
      wait_perm();
      tests_run++;
      if (timed_out || perm_cycles != 0) begin
        tests_failed++;
        $display("FAIL bypass%0d_perm_cycles: got %0d want 0", c, perm_cycles);
      end
      drain(1'b0, 1'b0);
      for (int k = 0; k < DEPTH; k++) begin
        tests_run++;
        if (timed_out || vout[k] !== vin[k]) begin
          tests_failed++;
          $display("FAIL bypass%0d_slice%0d: got %h want %h", c, k, vout[k], vin[k]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < DEPTH; k++) begin
      vin[k]  = 25'($urandom);
      vexp[k] = model_fwd(model_fwd(vin[k]));
    end
    send_state(2'd1, 5'd2);
    wait_perm();
    tests_run++;
    if (timed_out || perm_cycles != 2 * DEPTH) begin
      tests_failed++; $display("FAIL bp_perm_cycles: got %0d want %0d", perm_cycles, 2 * DEPTH);
    end
    drain(1'b1, 1'b1);
    tests_run++;
    if (timed_out) begin
      tests_failed++; $display("FAIL bp_timeout: drain did not complete");
    end
    tests_run++;
    if (stall_errs != 0) begin
      tests_failed++; $display("FAIL bp_stable: got %0d unstable stalls want 0", stall_errs);
    end
    tests_run++;
    if (ready_errs != 0) begin
      tests_failed++; $display("FAIL bp_handshake: got %0d cycles with in_ready=1 or out_valid=0 want 0", ready_errs);
    end
    for (int k = 0; k < DEPTH; k++) begin
      tests_run++;
      if (vout[k] !== vexp[k]) begin
        tests_failed++;
        $display("FAIL bp_slice%0d: got %h want %h", k, vout[k], vexp[k]);
      end
    end
    tests_run++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_back_to_idle: in_ready=%b busy=%b want 1/0", in_ready, busy);
    end
  endtask

  task automatic test_reset_mid_perm();
    int spurious;
    for (int k = 0; k < DEPTH; k++) vin[k] = 25'($urandom);
    send_state(2'd1, 5'd3);
    repeat (2) begin
      @(posedge clk); #1;
    end
    tests_run++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstperm_in_perm: busy=%b in_ready=%b out_valid=%b want 1/0/0", busy, in_ready, out_valid);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rstperm_after: busy=%b out_valid=%b in_ready=%b want 0/0/1", busy, out_valid, in_ready);
    end
    spurious = 0;
    out_ready = 1'b1;
    repeat (20) begin
      if (out_valid !== 1'b0 || busy !== 1'b0) spurious++;
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    tests_run++;
    if (spurious != 0) begin
      tests_failed++; $display("FAIL rstperm_quiet: got %0d active cycles want 0", spurious);
    end
    run_directed("rstperm_fresh");
  endtask

  task automatic test_saturate();
    for (int k = 0; k < DEPTH; k++) begin
      vin[k]  = 25'($urandom);
      vexp[k] = vin[k];
      for (int r = 0; r < MAX_ROUNDS; r++) vexp[k] = model_fwd(vexp[k]);
    end
    send_state(2'd1, RW'(MAX_ROUNDS + 3));
    wait_perm();
    tests_run++;
    if (timed_out || perm_cycles != MAX_ROUNDS * DEPTH) begin
      tests_failed++;
      $display("FAIL sat_perm_cycles: got %0d want %0d", perm_cycles, MAX_ROUNDS * DEPTH);
    end
    drain(1'b0, 1'b0);
    for (int k = 0; k < DEPTH; k++) begin
      tests_run++;
      if (timed_out || vout[k] !== vexp[k]) begin
        tests_failed++;
        $display("FAIL sat_slice%0d: got %h want %h", k, vout[k], vexp[k]);
      end
    end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    mode = 2'd0;
    rounds = '0;
    out_ready = 1'b0;
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_fwd_vectors();
    test_fwd_inv_roundtrip();
    test_bypass();
    test_backpressure();
    test_reset_mid_perm();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
